// File: rtl/alu_bit_serial_sequencer.sv
// alu_bit_serial_sequencer
// Runs a full-width RISC-V ALU operation through an external combinational
// one-bit ALU slice. The operation takes one bit per clock, LSB first. The
// block latches the operands and the decoded slice controls. It threads the
// carry between bit positions through a register, assembles the result and
// produces the zero, carry and overflow flags.
// Optional feature: define ALU_SLT_EN to enable set-less-than (alu_op 0111).
// Without it, 0111 is treated like any other unsupported code (AND).

module alu_bit_serial_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_a_invert,
  output logic             slice_b_invert,
  output logic             slice_carry_in,
  output logic [1:0]       slice_operation,
  input  logic             slice_result,
  input  logic             slice_carry_out
);

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] SLICE_AND = 2'b00;
  localparam logic [1:0] SLICE_OR  = 2'b01;
  localparam logic [1:0] SLICE_SUM = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Slice controls plus the two flags that select how the final bit is handled.
  typedef struct packed {
    logic       a_inv;
    logic       b_inv;
    logic [1:0] op;
    logic       arith;
    logic       slt;
  } ctrl_t;

  // Map the 4-bit ALU control onto slice controls. Unknown codes fall back to AND.
  function automatic ctrl_t decode_op(input logic [3:0] code);
    ctrl_t c;
    c.a_inv = 1'b0;
    c.b_inv = 1'b0;
    c.op    = SLICE_AND;
    c.arith = 1'b0;
    c.slt   = 1'b0;
    case (code)
      4'b0000: c.op = SLICE_AND;
      4'b0001: c.op = SLICE_OR;
      4'b0010: begin
        c.op    = SLICE_SUM;
        c.arith = 1'b1;
      end
      4'b0110: begin
        c.b_inv = 1'b1;
        c.op    = SLICE_SUM;
        c.arith = 1'b1;
      end
      4'b1100: begin
        c.a_inv = 1'b1;
        c.b_inv = 1'b1;
        c.op    = SLICE_AND;
      end
`ifdef ALU_SLT_EN
      4'b0111: begin
        c.b_inv = 1'b1;
        c.op    = SLICE_SUM;
        c.arith = 1'b1;
        c.slt   = 1'b1;
      end
`endif
      default: c.op = SLICE_AND;
    endcase
    return c;
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  ctrl_t            ctrl_r;
  ctrl_t            start_ctrl_s;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             carry_out_r;
  logic             overflow_r;
  logic             last_bit_s;
  logic             ovf_s;
  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] final_s;

  assign start_ctrl_s = decode_op(alu_op);

  // Build the result candidates for this cycle: shift in the slice bit, then apply SLT on the last bit.
  always_comb begin
    last_bit_s = (cnt_r == LAST_BIT);
    ovf_s      = carry_r ^ slice_carry_out;
    shifted_s  = {slice_result, result_r[WIDTH-1:1]};
    final_s    = shifted_s;
    if (ctrl_r.slt) begin
      // The sign of the difference, corrected for overflow, gives "a < b".
      final_s    = '0;
      final_s[0] = slice_result ^ ovf_s;
    end else begin
      final_s = shifted_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and the status and slice drive outputs.
  always_comb begin
    state_s         = state_r;
    busy            = 1'b0;
    done            = 1'b0;
    slice_a         = 1'b0;
    slice_b         = 1'b0;
    slice_a_invert  = 1'b0;
    slice_b_invert  = 1'b0;
    slice_carry_in  = 1'b0;
    slice_operation = SLICE_AND;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        busy            = 1'b1;
        slice_a         = a_sh_r[0];
        slice_b         = b_sh_r[0];
        slice_a_invert  = ctrl_r.a_inv;
        slice_b_invert  = ctrl_r.b_inv;
        slice_carry_in  = carry_r;
        slice_operation = ctrl_r.op;
        if (last_bit_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Latch operands and controls on start, step one bit per RUN cycle, and capture the flags on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      ctrl_r      <= '0;
      cnt_r       <= '0;
      carry_r     <= 1'b0;
      result_r    <= '0;
      zero_r      <= 1'b0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sh_r      <= op_a;
            b_sh_r      <= op_b;
            ctrl_r      <= start_ctrl_s;
            cnt_r       <= '0;
            // Subtraction is a + ~b + 1, so the carry chain starts at 1.
            carry_r     <= start_ctrl_s.b_inv & start_ctrl_s.arith;
            result_r    <= '0;
            zero_r      <= 1'b0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
          end
        end
        RUN: begin
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r <= slice_carry_out;
          cnt_r   <= cnt_r + CW'(1);
          if (last_bit_s) begin
            result_r    <= final_s;
            zero_r      <= (final_s == '0);
            carry_out_r <= ctrl_r.arith & slice_carry_out;
            overflow_r  <= ctrl_r.arith & ovf_s;
          end else begin
            result_r <= shifted_s;
          end
        end
        DONE: begin
          // The result and flags stay as they are until the next accepted start.
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign result    = result_r;
  assign zero      = zero_r;
  assign carry_out = carry_out_r;
  assign overflow  = overflow_r;

endmodule
